// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: operand forwarding and hazard control for a 5-stage
// integer pipeline. The block keeps shadow destination tags for the EX, MEM
// and WB stages. From these it builds registered forwarding selects for the
// EX operand muxes. It also raises a load-use stall/bubble and a taken-branch
// flush, and it counts both events with saturating counters.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   hold                  global freeze: every register keeps its value
//   id_*                  decode-stage instruction fields
//   ex_branch_taken       branch/jump resolved taken in EX
//   operand{1,2}_select   registered EX forwarding selects (00 RF, 10 EX/MEM, 11 MEM/WB)
//   stall_if_id           combinational: hold PC and IF/ID
//   bubble_id_ex          combinational: load NOP into ID/EX
//   flush_if_id           combinational: squash IF/ID
//   stall_count, flush_count  saturating event counters
module hazard_forward_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  output logic [1:0]       operand1_select,
  output logic [1:0]       operand2_select,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b10;
  localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } dst_tag_t;

  typedef struct packed {
    dst_tag_t         dst;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             uses_rs1;
    logic             uses_rs2;
  } ex_tag_t;

  ex_tag_t          ex_q,   ex_d;
  dst_tag_t         mem_q,  mem_d;
  dst_tag_t         wb_q,   wb_d;
  logic [SEL_W-1:0] op1_sel_q, op1_sel_d;
  logic [SEL_W-1:0] op2_sel_q, op2_sel_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu_c;
  logic stall_c;
  logic bubble_c;
  logic flush_c;

  // The WB tag and the EX source fields are shadow state for debug visibility.
  // No logic consumes them, so they are folded into this sink.
  logic unused_tag_bits_c;
  assign unused_tag_bits_c = ^{wb_q, ex_q.rs1, ex_q.rs2, ex_q.uses_rs1, ex_q.uses_rs2};

  // A tag "writes r" only for a live, register-writing producer of a non-x0 register.
  function automatic logic tag_writes(input dst_tag_t t, input logic [REG_W-1:0] r);
    return t.valid & t.reg_write & (t.rd == r) & (r != REG_W'(0));
  endfunction

  // Nearest producer wins: the EX tag (result moving to EX/MEM) beats the MEM tag.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic uses, input logic [REG_W-1:0] rs,
                                               input dst_tag_t near, input dst_tag_t far);
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (uses && tag_writes(near, rs)) begin
      sel = SEL_EXMEM;
    end else if (uses && tag_writes(far, rs)) begin
      sel = SEL_MEMWB;
    end
    return sel;
  endfunction

  // Load-use detect against the load currently in EX.
  always_comb begin
    lu_c = id_valid & ex_q.dst.valid & ex_q.dst.mem_read & ex_q.dst.reg_write &
           (ex_q.dst.rd != REG_W'(0)) &
           ((id_uses_rs1 & (id_rs1 == ex_q.dst.rd)) |
            (id_uses_rs2 & (id_rs2 == ex_q.dst.rd)));
  end

  // Pipeline control: a taken branch overrides a load-use stall; hold masks everything.
  always_comb begin
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (!hold) begin
      if (ex_branch_taken) begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
      end else if (lu_c) begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
    end
  end

  // Tag advance, select generation and counters.
  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    op1_sel_d   = op1_sel_q;
    op2_sel_d   = op2_sel_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q.dst;
      if (bubble_c) begin
        ex_d      = '0;
        op1_sel_d = SEL_RF;
        op2_sel_d = SEL_RF;
      end else begin
        ex_d.dst.valid     = id_valid;
        ex_d.dst.rd        = id_rd;
        ex_d.dst.reg_write = id_reg_write;
        ex_d.dst.mem_read  = id_mem_read;
        ex_d.rs1           = id_rs1;
        ex_d.rs2           = id_rs2;
        ex_d.uses_rs1      = id_uses_rs1;
        ex_d.uses_rs2      = id_uses_rs2;
        op1_sel_d = fwd_sel(id_uses_rs1, id_rs1, ex_q.dst, mem_q);
        op2_sel_d = fwd_sel(id_uses_rs2, id_rs2, ex_q.dst, mem_q);
      end
      if (stall_c && stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_c && flush_cnt_q != CNT_MAX) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset overrides hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      op1_sel_q   <= SEL_RF;
      op2_sel_q   <= SEL_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      op1_sel_q   <= op1_sel_d;
      op2_sel_q   <= op2_sel_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign operand1_select = op1_sel_q;
  assign operand2_select = op2_sel_q;
  assign stall_if_id     = stall_c;
  assign bubble_id_ex    = bubble_c;
  assign flush_if_id     = flush_c;
  assign stall_count     = stall_cnt_q;
  assign flush_count     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl. A 16-bit-counter instance carries the
// main checks. A 2-bit-counter instance shares the same inputs so that counter
// saturation is reachable in a few stalls.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic       ex_branch_taken;

  logic [1:0]  op1, op2;
  logic        stall, bubble, flush;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  s_op1, s_op2;
  logic        s_stall, s_bubble, s_flush;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .operand1_select(op1), .operand2_select(op2),
    .stall_if_id(stall), .bubble_id_ex(bubble), .flush_if_id(flush),
    .stall_count(stall_cnt), .flush_count(flush_cnt)
  );

  hazard_forward_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .operand1_select(s_op1), .operand2_select(s_op2),
    .stall_if_id(s_stall), .bubble_id_ex(s_bubble), .flush_if_id(s_flush),
    .stall_count(s_stall_cnt), .flush_count(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the decode-stage instruction, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; ex_branch_taken = 1'b0;
    nop();
    do_reset();

    // Reset state
    chk("rst_op1", 32'(op1), 32'h0);
    chk("rst_op2", 32'(op2), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_bubble", 32'(bubble), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);

    // add x5,x1,x2 ; sub x6,x5,x3 -> op1=10, op2=00, no stall
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    chk("t1_add_stall", 32'(stall), 32'h0);
    tick();
    drive(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("t1_sub_stall", 32'(stall), 32'h0);
    tick();
    chk("t1_sub_op1", 32'(op1), 32'h2);
    chk("t1_sub_op2", 32'(op2), 32'h0);

    // add x5 ; nop ; or x7,x4,x5 -> op2=11
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    drive(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    chk("t2_or_op1", 32'(op1), 32'h0);
    chk("t2_or_op2", 32'(op2), 32'h3);

    // add x5 ; add x5 ; and x8,x5,x5 -> both 10
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    chk("t3_and_op1", 32'(op1), 32'h2);
    chk("t3_and_op2", 32'(op2), 32'h2);

    // lw x9,0(x1) ; add x10,x9,x9 -> one stall cycle, then both selects 11
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    chk("t4_lw_stall", 32'(stall), 32'h0);
    tick();
    drive(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    chk("t4_lu_stall", 32'(stall), 32'h1);
    chk("t4_lu_bubble", 32'(bubble), 32'h1);
    chk("t4_lu_flush", 32'(flush), 32'h0);
    chk("t4_cnt_before", 32'(stall_cnt), 32'h0);
    tick();
    chk("t4_cnt_after", 32'(stall_cnt), 32'h1);
    chk("t4_bubble_op1", 32'(op1), 32'h0);
    chk("t4_stall_drop", 32'(stall), 32'h0);
    tick();
    chk("t4_add_op1", 32'(op1), 32'h3);
    chk("t4_add_op2", 32'(op2), 32'h3);
    chk("t4_cnt_hold", 32'(stall_cnt), 32'h1);

    // Reset clears counters and tags
    nop();
    do_reset();
    chk("r2_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("r2_op1", 32'(op1), 32'h0);

    // lw x9 ; add x10,x9,x0 with branch taken -> flush wins
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    ex_branch_taken = 1'b1;
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    chk("t5_flush", 32'(flush), 32'h1);
    chk("t5_stall", 32'(stall), 32'h0);
    chk("t5_bubble", 32'(bubble), 32'h1);
    tick();
    ex_branch_taken = 1'b0;
    chk("t5_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("t5_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("t5_op1", 32'(op1), 32'h0);

    // x0 producer / load into x0, then consumer of x0 -> no forward, no stall
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    chk("t6_x0_stall", 32'(stall), 32'h0);
    tick();
    chk("t6_x0_op1", 32'(op1), 32'h0);
    chk("t6_x0_op2", 32'(op2), 32'h0);

    // Hold for 3 cycles: selects, tags and counters frozen; controls masked
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    chk("t7_pre_op1", 32'(op1), 32'h2);
    hold = 1'b1;
    ex_branch_taken = 1'b1;
    drive(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    chk("t7_hold_flush", 32'(flush), 32'h0);
    chk("t7_hold_bubble", 32'(bubble), 32'h0);
    tick();
    tick();
    tick();
    chk("t7_hold_op1", 32'(op1), 32'h2);
    chk("t7_hold_op2", 32'(op2), 32'h0);
    chk("t7_hold_flush_cnt", 32'(flush_cnt), 32'h1);
    chk("t7_hold_stall_cnt", 32'(stall_cnt), 32'h0);
    hold = 1'b0;
    ex_branch_taken = 1'b0;
    #1;
    tick();
    chk("t7_rel_op1", 32'(op1), 32'h0);
    chk("t7_rel_op2", 32'(op2), 32'h3);

    // Four load-use stalls: 16-bit counter reaches 4, 2-bit counter sticks at 3
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
      tick();
      drive(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
      tick();
      tick();
    end
    chk("t8_stall_cnt", 32'(stall_cnt), 32'h4);
    chk("t8_sat_stall_cnt", 32'(s_stall_cnt), 32'h3);
    chk("t8_sat_flush_cnt", 32'(s_flush_cnt), 32'h1);

    // Reset in the middle of a stall returns everything to reset values
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    chk("t9_mid_stall", 32'(stall), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t9_rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("t9_rst_op1", 32'(op1), 32'h0);
    chk("t9_rst_stall", 32'(stall), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
